// File: rtl/noc_mem_target.sv
// noc_mem_target: NoC endpoint responder for one mesh node.
//
// Request flits arrive on the node's req port. Each flit is a single-beat
// read, write or ping of a local 16-bit word memory. Every request returns
// exactly one response flit on the rsp port, in the order it was accepted.
// Each response is routed back to the requester's tid.
//
// Pipeline:
//   S0  handshake (req_tvalid & req_tready)
//   S1  registered request; memory write commits, read data is looked up
//       and the response is formed
//   S2  response written into the response FIFO
//   The registered FIFO head drives rsp_*.
// Latency: a request accepted in cycle N gives rsp_tvalid in cycle N+2.
// Throughput is one flit per cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_tvalid/tready         request handshake
//   req_tdata[31:0]           [31:16] word address, [15:0] write data
//   req_tid                   requester id, returned on rsp_tdest
//   req_tdest                 ignored (flit already routed here)
//   req_tuser[1:0]            opcode: 00 read, 01 write, 10 ping, 11 reserved
//   rsp_tvalid/tready         response handshake
//   rsp_tdata[31:0]           read data, echoed request, or 32'hDEAD_BEEF
//   rsp_tid                   NODE_ID
//   rsp_tdest                 requester id (low TDEST_W bits)
//   rsp_tuser                 [1:0] opcode echo, [2] error, upper bits zero
//   err_cnt[7:0]              saturating count of error responses
//
// Build option: define NOC_MEM_TARGET_ERR_CNT_EN to enable err_cnt.
// When it is not defined, err_cnt is tied to zero.
module noc_mem_target #(
   parameter int TID_W     = 6,
   parameter int TDEST_W   = 5,
   parameter int TUSER_W   = 5,
   parameter int NODE_ID   = 0,
   parameter int MEM_DEPTH = 64,
   parameter int RSP_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_tvalid,
   output logic               req_tready,
   input  logic [31:0]        req_tdata,
   input  logic [TID_W-1:0]   req_tid,
   input  logic [TDEST_W-1:0] req_tdest,
   input  logic [TUSER_W-1:0] req_tuser,
   output logic               rsp_tvalid,
   input  logic               rsp_tready,
   output logic [31:0]        rsp_tdata,
   output logic [TID_W-1:0]   rsp_tid,
   output logic [TDEST_W-1:0] rsp_tdest,
   output logic [TUSER_W-1:0] rsp_tuser,
   output logic [7:0]         err_cnt
);
   localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int PTR_W  = $clog2(RSP_DEPTH);
   localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_PING  = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   logic [15:0]        mem [MEM_DEPTH];

   logic               s1_v;
   op_e                s1_op;
   logic [31:0]        s1_tdata;
   logic [TDEST_W-1:0] s1_dest;
   logic               s1_err;
   logic               addr_bad;
   logic [31:0]        s1_rsp_data;
   logic               mem_we;

   logic [31:0]        fifo_data [RSP_DEPTH];
   logic [TDEST_W-1:0] fifo_dest [RSP_DEPTH];
   logic [2:0]         fifo_user [RSP_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W:0]     credits_used;
   logic               req_fire, push, pop;

   // Credits cover both queued responses and the one flit that may sit in S1.
   // Because of this, the FIFO can never be pushed while it is full.
   assign credits_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(s1_v);
   assign req_tready   = !rst && (credits_used < (CNT_W+1)'(RSP_DEPTH));
   assign req_fire     = req_tvalid && req_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v     <= 1'b0;
         s1_op    <= OP_READ;
         s1_tdata <= '0;
         s1_dest  <= '0;
      end else begin
         s1_v <= req_fire;
         if (req_fire) begin
            s1_op    <= op_e'(req_tuser[1:0]);
            s1_tdata <= req_tdata;
            s1_dest  <= req_tid[TDEST_W-1:0];
         end
      end
   end

   // Any address bit at or above MEM_DEPTH is an error. Out-of-range
   // addresses must never alias onto a valid word.
   assign addr_bad = {16'h0000, s1_tdata[31:16]} >= 32'(MEM_DEPTH);

   always_comb begin
      s1_err      = 1'b0;
      s1_rsp_data = s1_tdata;
      case (s1_op)
         OP_READ: begin
            s1_err      = addr_bad;
            s1_rsp_data = {16'h0000, mem[s1_tdata[16 +: ADDR_W]]};
         end
         OP_WRITE: s1_err = addr_bad;
         OP_PING:  s1_err = 1'b0;
         default:  s1_err = 1'b1;
      endcase
      if (s1_err) s1_rsp_data = 32'hDEAD_BEEF;
   end

   // The write commits at the end of S1. A read in the following S1 cycle
   // therefore sees the new data without any bypass path. The write is
   // suppressed in a reset cycle.
   assign mem_we = s1_v && (s1_op == OP_WRITE) && !addr_bad && !rst;

   always_ff @(posedge clk) begin
      if (mem_we) mem[s1_tdata[16 +: ADDR_W]] <= s1_tdata[15:0];
   end

   assign push = s1_v;
   assign pop  = rsp_tvalid && rsp_tready;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= s1_rsp_data;
         fifo_dest[wr_ptr] <= s1_dest;
         fifo_user[wr_ptr] <= {s1_err, s1_op};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Payload outputs are forced to zero while the FIFO is empty. Stale
   // entries therefore never show on the bus, including right after reset.
   assign rsp_tvalid = (fifo_count != '0);
   assign rsp_tdata  = rsp_tvalid ? fifo_data[rd_ptr] : '0;
   assign rsp_tid    = rsp_tvalid ? TID_W'(NODE_ID) : '0;
   assign rsp_tdest  = rsp_tvalid ? fifo_dest[rd_ptr] : '0;
   assign rsp_tuser  = rsp_tvalid ? TUSER_W'(fifo_user[rd_ptr]) : '0;

`ifdef NOC_MEM_TARGET_ERR_CNT_EN
   logic [7:0] err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 8'h00;
      end else if (push && s1_err && (err_q != 8'hFF)) begin
         err_q <= err_q + 8'd1;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'h00;
`endif

   logic unused_req;
   assign unused_req = ^{req_tdest, req_tuser, req_tid};

endmodule

// File: tb/tb_noc_mem_target.sv
module tb_noc_mem_target;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_tvalid = 1'b0;
   logic        req_tready;
   logic [31:0] req_tdata = '0;
   logic [5:0]  req_tid = '0;
   logic [4:0]  req_tdest = '0;
   logic [4:0]  req_tuser = '0;
   logic        rsp_tvalid;
   logic        rsp_tready = 1'b1;
   logic [31:0] rsp_tdata;
   logic [5:0]  rsp_tid;
   logic [4:0]  rsp_tdest;
   logic [4:0]  rsp_tuser;
   logic [7:0]  err_cnt;

   noc_mem_target #(
      .TID_W(6), .TDEST_W(5), .TUSER_W(5), .NODE_ID(6), .MEM_DEPTH(64), .RSP_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
      .req_tid(req_tid), .req_tdest(req_tdest), .req_tuser(req_tuser),
      .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata),
      .rsp_tid(rsp_tid), .rsp_tdest(rsp_tdest), .rsp_tuser(rsp_tuser),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic [5:0]  tid;
      logic [4:0]  dest;
      logic [4:0]  user;
      int unsigned c;
   } rsp_t;

   rsp_t rsp_q[$];

   always @(negedge clk) begin
      if (rsp_tvalid && rsp_tready) begin
         rsp_t r;
         r.data = rsp_tdata;
         r.tid  = rsp_tid;
         r.dest = rsp_tdest;
         r.user = rsp_tuser;
         r.c    = cyc;
         rsp_q.push_back(r);
      end
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] data;
      logic [5:0]  tid;
      logic [31:0] exp_data;
      logic [2:0]  exp_user;
   } vec_t;

   vec_t vt [14];

   int n_vec = 0;
   int n_err = 0;
   int model_err = 0;

   function automatic logic [31:0] exp_errcnt();
`ifdef NOC_MEM_TARGET_ERR_CNT_EN
      return (model_err > 255) ? 32'd255 : 32'(model_err);
`else
      return 32'd0;
`endif
   endfunction

   task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, got, want);
      end
   endtask

   task automatic check_rsp(input string nm, input rsp_t r, input logic [31:0] ed,
                            input logic [2:0] eu, input logic [4:0] edest);
      n_vec++;
      if (r.data !== ed || r.user !== {2'b00, eu} || r.dest !== edest || r.tid !== 6'd6) begin
         n_err++;
         $display("FAIL %s: got data=%h user=%b dest=%h tid=%h, want data=%h user=%b dest=%h tid=06",
                  nm, r.data, r.user, r.dest, r.tid, ed, {2'b00, eu}, edest);
      end
   endtask

   task automatic send_req(input string nm, input logic [1:0] op, input logic [31:0] d,
                           input logic [5:0] tid);
      bit done;
      done = 1'b0;
      @(posedge clk); #1;
      req_tvalid = 1'b1;
      req_tuser  = {3'b000, op};
      req_tdata  = d;
      req_tid    = tid;
      req_tdest  = 5'h1F;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (req_tready) done = 1'b1;
         @(posedge clk); #1;
      end
      req_tvalid = 1'b0;
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: request not accepted within 50 cycles", nm);
      end
   endtask

   task automatic get_rsp(input string nm, output rsp_t r, output bit ok);
      ok = 1'b0;
      r  = '{default: 0};
      for (int i = 0; i < 60; i++) begin
         if (rsp_q.size() > 0) begin
            r  = rsp_q.pop_front();
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no response within 60 cycles", nm);
      end
   endtask

   task automatic xact(input string nm, input logic [1:0] op, input logic [31:0] d,
                       input logic [5:0] tid, input logic [31:0] ed, input logic [2:0] eu);
      rsp_t r;
      bit   ok;
      send_req(nm, op, d, tid);
      get_rsp(nm, r, ok);
      if (ok) check_rsp(nm, r, ed, eu, tid[4:0]);
      if (eu[2]) model_err++;
      check_val({nm, "_errcnt"}, {24'h0, err_cnt}, exp_errcnt());
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rsp_t        r1, r2;
      bit          ok1, ok2, fire;
      int unsigned c0;
      int          acc, unstable;
      logic [31:0] d;

      vt[0]  = '{2'b01, 32'h0005_1234, 6'd3,    32'h0005_1234, 3'b001};
      vt[1]  = '{2'b00, 32'h0005_0000, 6'd3,    32'h0000_1234, 3'b000};
      vt[2]  = '{2'b10, 32'hCAFE_F00D, 6'd9,    32'hCAFE_F00D, 3'b010};
      vt[3]  = '{2'b01, 32'h0001_5555, 6'd1,    32'h0001_5555, 3'b001};
      vt[4]  = '{2'b00, 32'h0040_0000, 6'd1,    32'hDEAD_BEEF, 3'b100};
      vt[5]  = '{2'b11, 32'h0001_0000, 6'd2,    32'hDEAD_BEEF, 3'b111};
      vt[6]  = '{2'b00, 32'h0001_0000, 6'd2,    32'h0000_5555, 3'b000};
      vt[7]  = '{2'b01, 32'h003F_BEEF, 6'd5,    32'h003F_BEEF, 3'b001};
      vt[8]  = '{2'b00, 32'h003F_0000, 6'd5,    32'h0000_BEEF, 3'b000};
      vt[9]  = '{2'b01, 32'h0000_1111, 6'd7,    32'h0000_1111, 3'b001};
      vt[10] = '{2'b01, 32'h0140_7777, 6'd7,    32'hDEAD_BEEF, 3'b101};
      vt[11] = '{2'b00, 32'h0000_0000, 6'd7,    32'h0000_1111, 3'b000};
      vt[12] = '{2'b10, 32'hFFFF_0001, 6'h25,   32'hFFFF_0001, 3'b010};
      vt[13] = '{2'b00, 32'hFFFF_0000, 6'h3F,   32'hDEAD_BEEF, 3'b100};

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_tready_low", {31'h0, req_tready}, 32'd0);
      check_val("rst_tvalid_low", {31'h0, rsp_tvalid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_tready", {31'h0, req_tready}, 32'd1);
      check_val("post_rst_tvalid", {31'h0, rsp_tvalid}, 32'd0);
      check_val("post_rst_fields", {rsp_tdata ^ {rsp_tid, rsp_tdest, rsp_tuser, 16'h0}}, 32'd0);
      check_val("post_rst_errcnt", {24'h0, err_cnt}, 32'd0);

      // Table of directed vectors
      for (int i = 0; i < 14; i++) begin
         xact($sformatf("vec%0d", i), vt[i].op, vt[i].data, vt[i].tid, vt[i].exp_data, vt[i].exp_user);
      end

      // Back-to-back write then read of the same address
      @(posedge clk); #1;
      req_tvalid = 1'b1; req_tuser = 5'd1; req_tdata = 32'h0007_ABCD; req_tid = 6'd4;
      @(negedge clk);
      ok1 = req_tready;
      c0  = cyc;
      @(posedge clk); #1;
      req_tuser = 5'd0; req_tdata = 32'h0007_0000;
      @(negedge clk);
      ok2 = req_tready;
      @(posedge clk); #1;
      req_tvalid = 1'b0;
      check_val("b2b_accept", {30'h0, ok1, ok2}, 32'd3);
      get_rsp("b2b_wr", r1, ok1);
      get_rsp("b2b_rd", r2, ok2);
      if (ok1) begin
         check_rsp("b2b_wr", r1, 32'h0007_ABCD, 3'b001, 5'd4);
         check_val("b2b_wr_cycle", r1.c, c0 + 2);
      end
      if (ok2) begin
         check_rsp("b2b_rd", r2, 32'h0000_ABCD, 3'b000, 5'd4);
         check_val("b2b_rd_cycle", r2.c, c0 + 3);
      end

      // Fill addresses 10..19 with 0x1000+i
      for (int i = 0; i < 10; i++) begin
         d = {16'(10 + i), 16'(16'h1000 + i)};
         xact("fill", 2'b01, d, 6'd11, d, 3'b001);
      end

      // Backpressure: 10 reads while rsp_tready is held low
      @(posedge clk); #1;
      rsp_tready = 1'b0;
      req_tvalid = 1'b1; req_tuser = 5'd0; req_tid = 6'd11;
      req_tdata  = {16'd10, 16'h0000};
      acc = 0;
      unstable = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         fire = req_tready;
         if (rsp_tvalid && (rsp_tdata !== 32'h0000_1000 || rsp_tuser !== 5'd0 || rsp_tdest !== 5'd11))
            unstable++;
         @(posedge clk); #1;
         if (fire) begin
            acc++;
            req_tdata = {16'(10 + acc), 16'h0000};
         end
      end
      @(negedge clk);
      check_val("bp_accepted", acc, 32'd4);
      check_val("bp_tready_low", {31'h0, req_tready}, 32'd0);
      check_val("bp_tvalid_high", {31'h0, rsp_tvalid}, 32'd1);
      check_val("bp_head_data", rsp_tdata, 32'h0000_1000);
      check_val("bp_unstable_cycles", unstable, 32'd0);
      @(posedge clk); #1;
      rsp_tready = 1'b1;
      for (int c = 0; c < 60 && acc < 10; c++) begin
         @(negedge clk);
         fire = req_tready;
         @(posedge clk); #1;
         if (fire) begin
            acc++;
            req_tdata = {16'(10 + acc), 16'h0000};
         end
      end
      req_tvalid = 1'b0;
      check_val("bp_total_accepted", acc, 32'd10);
      for (int i = 0; i < 10; i++) begin
         get_rsp("bp_rsp", r1, ok1);
         if (ok1) check_rsp($sformatf("bp_rsp%0d", i), r1, 32'h0000_1000 + 32'(i), 3'b000, 5'd11);
      end

      // Reset while three responses are queued
      @(posedge clk); #1;
      rsp_tready = 1'b0;
      send_req("mr0", 2'b00, 32'h000A_0000, 6'd11);
      send_req("mr1", 2'b00, 32'h000B_0000, 6'd11);
      send_req("mr2", 2'b00, 32'h000C_0000, 6'd11);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("mr_queued_valid", {31'h0, rsp_tvalid}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_tready = 1'b1;
      model_err = 0;
      @(negedge clk);
      check_val("mr_tvalid_cleared", {31'h0, rsp_tvalid}, 32'd0);
      check_val("mr_errcnt_cleared", {24'h0, err_cnt}, 32'd0);
      repeat (10) @(negedge clk);
      check_val("mr_no_stale", rsp_q.size(), 32'd0);
      xact("mr_read_after", 2'b00, 32'h000C_0000, 6'd11, 32'h0000_1002, 3'b000);

      // A write sitting in S1 during the reset cycle must not commit
      xact("s1rst_prewrite", 2'b01, 32'h0014_4444, 6'd2, 32'h0014_4444, 3'b001);
      @(posedge clk); #1;
      req_tvalid = 1'b1; req_tuser = 5'd1; req_tdata = 32'h0014_9999; req_tid = 6'd2;
      @(negedge clk);
      fire = req_tready;
      @(posedge clk); #1;
      req_tvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_err = 0;
      check_val("s1rst_accepted", {31'h0, fire}, 32'd1);
      xact("s1rst_read", 2'b00, 32'h0014_0000, 6'd2, 32'h0000_4444, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
